// File: rtl/credit_pkg.sv
// Shared types and helpers for the credit-based FIFO write-side sender.
package credit_pkg;

    localparam int DEFAULT_DEPTH = 16;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        DONE
    } sender_state_t;

    // One extra bit so the counter can hold the full value DEPTH.
    function automatic int credit_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/credit_counter.sv
// Credit pool: starts full, decrements on take, increments on give, saturates at
// DEPTH and flags a sticky error when a credit arrives while the pool is full.
module credit_counter
    import credit_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       take,
    input  logic                       give,
    output logic [credit_w(DEPTH)-1:0] count,
    output logic                       has_credit,
    output logic                       full,
    output logic                       err
);

    localparam int CREDIT_W = credit_w(DEPTH);
    localparam logic [CREDIT_W-1:0] FULL_CNT = CREDIT_W'(DEPTH);
    localparam logic [CREDIT_W-1:0] ONE      = CREDIT_W'(1);

    assign has_credit = (count != '0);
    assign full       = (count == FULL_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= FULL_CNT;
            err   <= 1'b0;
        end else begin
            if (take && !give) begin
                count <= count - ONE;
            end else if (give && !take) begin
                // A return into a full pool means the peer over-counted.
                if (full) begin
                    err <= 1'b1;
                end else begin
                    count <= count + ONE;
                end
            end
        end
    end

endmodule

// File: rtl/credit_stream_sender.sv
// Write-side transmitter for the credit-based async FIFO: 2-entry skid buffer,
// credit-gated launch, and a flush/quiesce state machine, all in wr_clk.
module credit_stream_sender
    import credit_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int DATA_W = 32
) (
    input  logic                       wr_clk,
    input  logic                       wr_rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       wr_valid,
    output logic [DATA_W-1:0]          wr_data,
    input  logic                       wr_credit_pulse,
    output logic [credit_w(DEPTH)-1:0] credits,
    output logic                       idle,
    input  logic                       flush_req,
    output logic                       flush_done,
    output logic                       credit_err
);

    logic [DATA_W-1:0] skid_q [2];
    logic [1:0]        skid_cnt;
    logic [1:0]        skid_cnt_nxt;
    sender_state_t     state;

    logic              xfer;
    logic              launch;
    logic              has_credit;
    logic              pool_full;
    logic              wr_idx;
    logic              bypass;
    logic [DATA_W-1:0] head;

    assign xfer         = in_valid && in_ready;
    assign head         = (skid_cnt != 2'd0) ? skid_q[0] : in_data;
    assign launch       = ((skid_cnt != 2'd0) || xfer) && has_credit;
    assign bypass       = launch && (skid_cnt == 2'd0);
    assign skid_cnt_nxt = skid_cnt + {1'b0, xfer} - {1'b0, launch};
    assign wr_idx       = (skid_cnt_nxt == 2'd2);

    assign idle = (skid_cnt == 2'd0) && !wr_valid && pool_full;

    credit_counter #(
        .DEPTH(DEPTH)
    ) u_credit_counter (
        .clk       (wr_clk),
        .rst_n     (wr_rst_n),
        .take      (launch),
        .give      (wr_credit_pulse),
        .count     (credits),
        .has_credit(has_credit),
        .full      (pool_full),
        .err       (credit_err)
    );

    // Skid storage holds data only; occupancy in skid_cnt says what is live.
    always_ff @(posedge wr_clk) begin
        if (launch && (skid_cnt != 2'd0)) begin
            skid_q[0] <= skid_q[1];
        end
        if (xfer && !bypass) begin
            skid_q[wr_idx] <= in_data;
        end
    end

    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            state      <= RUN;
            skid_cnt   <= 2'd0;
            in_ready   <= 1'b0;
            wr_valid   <= 1'b0;
            wr_data    <= '0;
            flush_done <= 1'b0;
        end else begin
            skid_cnt   <= skid_cnt_nxt;
            wr_valid   <= launch;
            flush_done <= 1'b0;
            if (launch) begin
                wr_data <= head;
            end
            case (state)
                RUN: begin
                    if (flush_req) begin
                        state    <= DRAIN;
                        in_ready <= 1'b0;
                    end else begin
                        in_ready <= (skid_cnt_nxt != 2'd2);
                    end
                end
                DRAIN: begin
                    in_ready <= 1'b0;
                    // Quiesced once every launched word has been consumed by the reader.
                    if ((skid_cnt == 2'd0) && pool_full) begin
                        state      <= DONE;
                        flush_done <= 1'b1;
                    end
                end
                DONE: begin
                    state    <= RUN;
                    in_ready <= (skid_cnt_nxt != 2'd2);
                end
                default: begin
                    state    <= RUN;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
